cntr_bank_cmd_seq: RTL and testbench
====================================

Name: cntr_bank_cmd_seq

Overview:
Per-bank DRAM command sequencer, directly downstream of the bank scheduler datapath. It consumes the single request selected by the scheduler exit mux (type, row, column, index, write data) and tracks the bank's open row. It issues the required ACT/PRE/RD/WR command sequence to the command-bus arbiter while enforcing tRCD, tRP, tRAS and tWR. Its consume strobe is the scheduler's pop, and it services refresh-close requests.

Parameters:
RA, 16, row address width
CA, 10, column address width
IDX, 6, transaction index width
DQ, 16, write data width
CNT_W, 5, timing counter width
T_RCD, 4, ACT to RD/WR, cycles
T_RP, 4, PRE to ACT, cycles
T_RAS, 10, ACT to PRE, cycles
T_WR, 6, WR to PRE, cycles

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
req_valid  in  1  scheduler has a popped-candidate request
req_type  in  1  1=READ, 0=WRITE
req_ra  in  RA  request row
req_ca  in  CA  request column
req_idx  in  IDX  request index
req_dq  in  DQ  write data; don't-care for reads
req_ready  out  1  request consumed this cycle (drives scheduler pop)
ref_req  in  1  refresh controller asks bank closed
ref_ack  out  1  one-cycle pulse: bank closed and tRP met
cmd_valid  out  1  command presented
cmd_ready  in  1  arbiter accepts command this cycle
cmd_op  out  2  0=ACT, 1=RD, 2=WR, 3=PRE
cmd_ra  out  RA  row for ACT, open row otherwise
cmd_ca  out  CA  column for RD/WR, 0 otherwise
cmd_idx  out  IDX  index for RD/WR
cmd_dq  out  DQ  write data for WR, 0 otherwise
row_open  out  1  bank has an open row
open_row  out  RA  currently open row (valid when row_open)

Behaviour:
- Reset (async assert, sync release): state IDLE, row_open=0, open_row=0, all counters 0, cmd_valid=0, cmd_op=0, cmd_ra/ca/idx/dq=0, req_ready=0, ref_ack=0.
- Counters: rcd_cnt, rp_cnt, ras_cnt, wr_cnt. Each decrements by 1 per cycle and saturates at 0. Each loads (T_x - 1) in the cycle its command is accepted. T_x must be >=1 and <2^CNT_W.
- Handshake: a command is accepted when cmd_valid && cmd_ready. Once raised, cmd_valid and its fields stay stable until accepted. Upstream holds req_* stable while req_valid && !req_ready.
- req_ready = (state==COL) && cmd_ready && cmd_valid. It is a combinational, single-cycle pulse coincident with RD/WR acceptance and is never asserted otherwise.
- States:
  IDLE: ref_req has priority over req_valid. With ref_req: go to PRE if row_open, else go to RPW. With req_valid only: go to COL if row_open && open_row==req_ra (hit), go to PRE if row_open && mismatch, go to ACT if closed. No command is issued in IDLE.
  PRE: cmd_valid asserts only when ras_cnt==0 && wr_cnt==0, with cmd_op=3. On accept: row_open=0, load rp_cnt, go to RPW.
  RPW: wait for rp_cnt==0. Then go to IDLE and pulse ref_ack if the pass was refresh-initiated; otherwise go to ACT.
  ACT: cmd_valid=1, cmd_op=0, cmd_ra=req_ra. On accept: row_open=1, open_row=req_ra, load rcd_cnt and ras_cnt, go to COL.
  COL: cmd_valid asserts only when rcd_cnt==0, with cmd_op=1 (read) or 2 (write) and fields taken from req_*. On accept: pulse req_ready; for a write, load wr_cnt. Go to IDLE.
- The refresh flag is latched when leaving IDLE on ref_req and cleared when ref_ack pulses. A ref_req that rises mid-sequence waits until IDLE. A request sequence already started is never abandoned.
- A read or write takes at least 1 cycle from IDLE to the hit command. A closed-bank access needs ACT plus T_RCD cycles before the column command.
- Reset asserted mid-sequence aborts the sequence immediately. The bank is then reported closed; the controller re-initialises the DRAM.
- row_open/open_row update in the cycle after ACT/PRE acceptance (registered).

Test Plan:
- Closed bank, read ra=0x0012 ca=0x040, cmd_ready=1 always -> ACT(ra=0x0012) accepted at cycle t. RD accepted at t+4 with req_ready=1 that cycle only. row_open=1, open_row=0x0012.
- Row hit write after the previous case, ra=0x0012 ca=0x080 dq=0xBEEF -> WR with no ACT or PRE, cmd_dq=0xBEEF, req_ready pulses once, wr_cnt loaded with 5.
- Row miss ra=0x0034 issued 2 cycles after an ACT -> PRE held off until ras_cnt=0 (cycle ACT+10). ACT(0x0034) follows exactly 4 cycles after PRE acceptance.
- cmd_ready held low 3 cycles during ACT -> cmd_valid and cmd_ra stay stable, req_ready stays 0, ACT accepted on the 4th cycle.
- ref_req with row open, arriving 1 cycle after a WR -> PRE waits for wr_cnt=0. ref_ack pulses once 4 cycles after PRE acceptance, row_open=0, and a pending req_valid is only served afterwards.
- rst pulsed during RCD wait -> all outputs zero asynchronously, row_open=0, and no RD issued after release.

Source files
------------

// File: rtl/cntr_bank_cmd_seq_if.sv
// Request/refresh/command bundle between the bank scheduler, the per-bank
// command sequencer and the command-bus arbiter.
//
// Handshake: a request is consumed in the cycle req_valid && req_ready, and
// the scheduler holds req_* stable until then. A command is accepted in the
// cycle cmd_valid && cmd_ready; once cmd_valid rises, it and cmd_* stay stable
// until acceptance. ref_req is held until the one-cycle ref_ack pulse.
interface cntr_bank_cmd_seq_if #(
  parameter int RA  = 16,
  parameter int CA  = 10,
  parameter int IDX = 6,
  parameter int DQ  = 16
);
  logic           req_valid;
  logic           req_type;
  logic [RA-1:0]  req_ra;
  logic [CA-1:0]  req_ca;
  logic [IDX-1:0] req_idx;
  logic [DQ-1:0]  req_dq;
  logic           req_ready;
  logic           ref_req;
  logic           ref_ack;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [1:0]     cmd_op;
  logic [RA-1:0]  cmd_ra;
  logic [CA-1:0]  cmd_ca;
  logic [IDX-1:0] cmd_idx;
  logic [DQ-1:0]  cmd_dq;
  logic           row_open;
  logic [RA-1:0]  open_row;

  modport master (
    output req_valid, req_type, req_ra, req_ca, req_idx, req_dq, ref_req, cmd_ready,
    input  req_ready, ref_ack, cmd_valid, cmd_op, cmd_ra, cmd_ca, cmd_idx, cmd_dq,
           row_open, open_row
  );

  modport slave (
    input  req_valid, req_type, req_ra, req_ca, req_idx, req_dq, ref_req, cmd_ready,
    output req_ready, ref_ack, cmd_valid, cmd_op, cmd_ra, cmd_ca, cmd_idx, cmd_dq,
           row_open, open_row
  );
endinterface

// File: rtl/cntr_bank_cmd_seq.sv
// Per-bank DRAM command sequencer: tracks the open row and issues ACT/PRE/RD/WR
// while enforcing tRCD, tRP, tRAS and tWR; also closes the bank for refresh.
module cntr_bank_cmd_seq #(
  parameter int RA    = 16,
  parameter int CA    = 10,
  parameter int IDX   = 6,
  parameter int DQ    = 16,
  parameter int CNT_W = 5,
  parameter int T_RCD = 4,
  parameter int T_RP  = 4,
  parameter int T_RAS = 10,
  parameter int T_WR  = 6
) (
  input  logic                clk,
  input  logic                rst,
  cntr_bank_cmd_seq_if.slave  bus,
  output logic [2:0]          dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_RPW  = 3'd2,
    S_ACT  = 3'd3,
    S_COL  = 3'd4
  } state_e;

  localparam logic [1:0] OP_ACT = 2'd0;
  localparam logic [1:0] OP_RD  = 2'd1;
  localparam logic [1:0] OP_WR  = 2'd2;
  localparam logic [1:0] OP_PRE = 2'd3;

  // Counters hold "cycles still to wait", so the command is legal at value 0.
  localparam logic [CNT_W-1:0] RCD_LD = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] RP_LD  = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] RAS_LD = CNT_W'(T_RAS - 1);
  localparam logic [CNT_W-1:0] WR_LD  = CNT_W'(T_WR - 1);

  state_e           state_q, state_d;
  logic             row_open_q, row_open_d;
  logic [RA-1:0]    open_row_q, open_row_d;
  logic             ref_flag_q, ref_flag_d;
  logic [CNT_W-1:0] rcd_cnt_q, rcd_cnt_d;
  logic [CNT_W-1:0] rp_cnt_q, rp_cnt_d;
  logic [CNT_W-1:0] ras_cnt_q, ras_cnt_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;

  logic             cmd_valid;
  logic             accept;
  logic [1:0]       cmd_op;
  logic [RA-1:0]    cmd_ra;
  logic [CA-1:0]    cmd_ca;
  logic [IDX-1:0]   cmd_idx;
  logic [DQ-1:0]    cmd_dq;
  logic             ref_ack;
  logic             row_hit;

  function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  assign row_hit = row_open_q && (open_row_q == bus.req_ra);

  always_comb begin
    cmd_valid = 1'b0;
    unique case (state_q)
      S_PRE:   cmd_valid = (ras_cnt_q == '0) && (wr_cnt_q == '0);
      S_ACT:   cmd_valid = (rp_cnt_q == '0);
      S_COL:   cmd_valid = (rcd_cnt_q == '0);
      default: cmd_valid = 1'b0;
    endcase
  end

  assign accept = cmd_valid && bus.cmd_ready;

  always_comb begin
    state_d    = state_q;
    row_open_d = row_open_q;
    open_row_d = open_row_q;
    ref_flag_d = ref_flag_q;
    rcd_cnt_d  = dec_sat(rcd_cnt_q);
    rp_cnt_d   = dec_sat(rp_cnt_q);
    ras_cnt_d  = dec_sat(ras_cnt_q);
    wr_cnt_d   = dec_sat(wr_cnt_q);
    cmd_op     = OP_ACT;
    cmd_ra     = open_row_q;
    cmd_ca     = '0;
    cmd_idx    = '0;
    cmd_dq     = '0;
    ref_ack    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.ref_req) begin
          ref_flag_d = 1'b1;
          state_d    = row_open_q ? S_PRE : S_RPW;
        end else if (bus.req_valid) begin
          if (row_hit)         state_d = S_COL;
          else if (row_open_q) state_d = S_PRE;
          else                 state_d = S_ACT;
        end
      end

      S_PRE: begin
        cmd_op = OP_PRE;
        if (accept) begin
          row_open_d = 1'b0;
          rp_cnt_d   = RP_LD;
          state_d    = S_RPW;
        end
      end

      S_RPW: begin
        // The ACT path leaves one cycle early so the ACT lands on the first
        // cycle tRP is met; the refresh path acknowledges on that same cycle.
        if (ref_flag_q) begin
          if (rp_cnt_q == '0) begin
            ref_ack    = 1'b1;
            ref_flag_d = 1'b0;
            state_d    = S_IDLE;
          end
        end else if (rp_cnt_q <= CNT_W'(1)) begin
          state_d = S_ACT;
        end
      end

      S_ACT: begin
        cmd_op = OP_ACT;
        cmd_ra = bus.req_ra;
        if (accept) begin
          row_open_d = 1'b1;
          open_row_d = bus.req_ra;
          rcd_cnt_d  = RCD_LD;
          ras_cnt_d  = RAS_LD;
          state_d    = S_COL;
        end
      end

      S_COL: begin
        cmd_op  = bus.req_type ? OP_RD : OP_WR;
        cmd_ca  = bus.req_ca;
        cmd_idx = bus.req_idx;
        cmd_dq  = bus.req_type ? '0 : bus.req_dq;
        if (accept) begin
          if (!bus.req_type) wr_cnt_d = WR_LD;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      row_open_q <= 1'b0;
      open_row_q <= '0;
      ref_flag_q <= 1'b0;
      rcd_cnt_q  <= '0;
      rp_cnt_q   <= '0;
      ras_cnt_q  <= '0;
      wr_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      row_open_q <= row_open_d;
      open_row_q <= open_row_d;
      ref_flag_q <= ref_flag_d;
      rcd_cnt_q  <= rcd_cnt_d;
      rp_cnt_q   <= rp_cnt_d;
      ras_cnt_q  <= ras_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

  // The pop pulse is exactly the column-command acceptance.
  assign bus.req_ready = (state_q == S_COL) && accept;
  assign bus.ref_ack   = ref_ack;
  assign bus.cmd_valid = cmd_valid;
  assign bus.cmd_op    = cmd_op;
  assign bus.cmd_ra    = cmd_ra;
  assign bus.cmd_ca    = cmd_ca;
  assign bus.cmd_idx   = cmd_idx;
  assign bus.cmd_dq    = cmd_dq;
  assign bus.row_open  = row_open_q;
  assign bus.open_row  = open_row_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_cntr_bank_cmd_seq.sv
// Bench for cntr_bank_cmd_seq: directed timing cases followed by randomized
// traffic, checked against a command-list and timing-rule reference model.
module tb_cntr_bank_cmd_seq;
  localparam int RA = 16, CA = 10, IDX = 6, DQ = 16, CNT_W = 5;
  localparam int T_RCD = 4, T_RP = 4, T_RAS = 10, T_WR = 6;
  localparam int W = 2 + RA + CA + IDX + DQ;
  localparam int BOUND = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] dbg_state;

  cntr_bank_cmd_seq_if #(.RA(RA), .CA(CA), .IDX(IDX), .DQ(DQ)) bus ();

  cntr_bank_cmd_seq #(
    .RA(RA), .CA(CA), .IDX(IDX), .DQ(DQ), .CNT_W(CNT_W),
    .T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS), .T_WR(T_WR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // reference model: open-row state, expected command list, last command times
  logic          m_open = 1'b0;
  logic [RA-1:0] m_row  = '0;
  logic [W-1:0]  exp_q[$];
  int exp_rr = 0, exp_ack = 0, rr_cnt = 0, ack_cnt = 0, acc_cnt = 0;
  int t_act = -1000, t_pre = -1000, t_wr = -1000, t_rd = -1000;

  function automatic logic [W-1:0] pack(input logic [1:0] op, input logic [RA-1:0] ra,
                                        input logic [CA-1:0] ca, input logic [IDX-1:0] idx,
                                        input logic [DQ-1:0] dq);
    return {op, ra, ca, idx, dq};
  endfunction

  function automatic void push_req(input bit typ, input logic [RA-1:0] ra, input logic [CA-1:0] ca,
                                   input logic [IDX-1:0] idx, input logic [DQ-1:0] dq);
    if (!(m_open && m_row == ra)) begin
      if (m_open) exp_q.push_back(pack(2'd3, m_row, '0, '0, '0));
      exp_q.push_back(pack(2'd0, ra, '0, '0, '0));
    end
    if (typ) exp_q.push_back(pack(2'd1, ra, ca, idx, '0));
    else     exp_q.push_back(pack(2'd2, ra, ca, idx, dq));
    m_open = 1'b1;
    m_row  = ra;
    exp_rr++;
  endfunction

  function automatic void push_ref();
    if (m_open) exp_q.push_back(pack(2'd3, m_row, '0, '0, '0));
    m_open = 1'b0;
    exp_ack++;
  endfunction

  // cmd_ready driver: 0 = always ready, 1 = random, 2 = manual
  int   rdy_mode = 0;
  logic rdy_man  = 1'b1;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1:       bus.cmd_ready = ($urandom_range(0, 3) != 0);
      2:       bus.cmd_ready = rdy_man;
      default: bus.cmd_ready = 1'b1;
    endcase
  end

  // scoreboard monitor, sampled on the falling edge
  logic         pend = 1'b0;
  logic [W-1:0] pend_f = '0;
  always @(negedge clk) begin : mon
    logic [W-1:0] act_f;
    logic [W-1:0] e;
    logic [1:0]   op;
    if (rst) begin
      pend = 1'b0;
    end else begin
      act_f = {bus.cmd_op, bus.cmd_ra, bus.cmd_ca, bus.cmd_idx, bus.cmd_dq};
      op    = bus.cmd_op;
      if (pend) begin
        check("hold_valid", bus.cmd_valid, 1);
        check("hold_fields", act_f, pend_f);
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        acc_cnt++;
        check("cmd_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          if (op == 2'd0 || op == 2'd3) act_f[DQ +: IDX] = '0;
          check("cmd_fields", act_f, e);
        end
        case (op)
          2'd0: begin check("tRP", (cyc - t_pre) >= T_RP, 1); t_act = cyc; end
          2'd1: begin check("tRCD", (cyc - t_act) >= T_RCD, 1); t_rd = cyc; end
          2'd2: begin check("tRCD", (cyc - t_act) >= T_RCD, 1); t_wr = cyc; end
          default: begin
            check("tRAS", (cyc - t_act) >= T_RAS, 1);
            check("tWR", (cyc - t_wr) >= T_WR, 1);
            t_pre = cyc;
          end
        endcase
        check("req_ready_col", bus.req_ready, (op == 2'd1 || op == 2'd2));
        if (bus.req_ready) rr_cnt++;
      end else begin
        check("req_ready_idle", bus.req_ready, 0);
      end
      if (bus.ref_ack) ack_cnt++;
      pend   = bus.cmd_valid && !bus.cmd_ready;
      pend_f = {bus.cmd_op, bus.cmd_ra, bus.cmd_ca, bus.cmd_idx, bus.cmd_dq};
    end
  end

  // driver tasks
  task automatic wait_rr();
    bit found = 0;
    for (int i = 0; i < BOUND && !found; i++) begin
      @(negedge clk);
      if (bus.req_ready) found = 1;
    end
    if (!found) check("req_ready_timeout", 0, 1);
  endtask

  task automatic wait_ack(output int ack_cyc);
    bit found = 0;
    ack_cyc = -1;
    for (int i = 0; i < BOUND && !found; i++) begin
      @(negedge clk);
      if (bus.ref_ack) begin found = 1; ack_cyc = cyc; end
    end
    if (!found) check("ref_ack_timeout", 0, 1);
  endtask

  task automatic drive_req(input bit typ, input logic [RA-1:0] ra, input logic [CA-1:0] ca,
                           input logic [IDX-1:0] idx, input logic [DQ-1:0] dq);
    bus.req_type  = typ;
    bus.req_ra    = ra;
    bus.req_ca    = ca;
    bus.req_idx   = idx;
    bus.req_dq    = dq;
    bus.req_valid = 1'b1;
  endtask

  task automatic do_req(input bit typ, input logic [RA-1:0] ra, input logic [CA-1:0] ca,
                        input logic [IDX-1:0] idx, input logic [DQ-1:0] dq);
    push_req(typ, ra, ca, idx, dq);
    @(posedge clk); #1;
    drive_req(typ, ra, ca, idx, dq);
    wait_rr();
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic do_ref();
    int ac;
    push_ref();
    @(posedge clk); #1;
    bus.ref_req = 1'b1;
    wait_ack(ac);
    check("ref_all_cmds_done", exp_q.size(), 0);
    @(posedge clk); #1;
    bus.ref_req = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check(tag, {bus.cmd_valid, bus.cmd_op, bus.cmd_ra, bus.cmd_ca, bus.cmd_idx, bus.cmd_dq}, 0);
    check({tag, "_flags"}, {bus.req_ready, bus.ref_ack, bus.row_open}, 0);
    check({tag, "_open_row"}, bus.open_row, 0);
  endtask

  // directed steps, then random traffic
  initial begin
    int a56, w, ac, rr_before, acc_before, c;
    bit seen;
    bus.req_valid = 1'b0; bus.req_type = 1'b0; bus.req_ra = '0; bus.req_ca = '0;
    bus.req_idx = '0; bus.req_dq = '0; bus.ref_req = 1'b0;
    #2;
    check_outputs_zero("reset");
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;

    // closed bank read
    do_req(1'b1, 16'h0012, 10'h040, 6'd1, 16'h0000);
    check("t1_act_to_rd", t_rd - t_act, T_RCD);
    check("t1_row_open", bus.row_open, 1);
    check("t1_open_row", bus.open_row, 16'h0012);
    check("t1_req_ready_once", rr_cnt, 1);

    // row hit write
    do_req(1'b0, 16'h0012, 10'h080, 6'd2, 16'hBEEF);
    check("t2_wr_cnt_load", dut.wr_cnt_q, T_WR - 1);
    check("t2_req_ready_once", rr_cnt, 2);
    check("t2_cmd_count", acc_cnt, 3);

    // row misses: PRE held by tRAS, ACT exactly tRP after PRE
    do_req(1'b1, 16'h0056, 10'h011, 6'd3, 16'h0000);
    a56 = t_act;
    do_req(1'b1, 16'h0034, 10'h022, 6'd4, 16'h0000);
    check("t3_pre_at_tras", t_pre - a56, T_RAS);
    check("t3_act_after_pre", t_act - t_pre, T_RP);
    check("t3_open_row", bus.open_row, 16'h0034);

    // refresh one cycle after a write, with a request pending
    do_req(1'b0, 16'h0034, 10'h1FF, 6'd5, 16'h5A5A);
    w = t_wr;
    push_ref();
    push_req(1'b1, 16'h0077, 10'h033, 6'd6, 16'h0000);
    rr_before = rr_cnt;
    bus.ref_req = 1'b1;
    drive_req(1'b1, 16'h0077, 10'h033, 6'd6, 16'h0000);
    wait_ack(ac);
    check("t5_pre_at_twr", t_pre - w, T_WR);
    check("t5_ack_after_pre", ac - t_pre, T_RP);
    check("t5_req_held", rr_cnt, rr_before);
    check("t5_pending_cmds", exp_q.size(), 2);
    @(posedge clk); #1;
    bus.ref_req = 1'b0;
    check("t5_row_closed", bus.row_open, 0);
    wait_rr();
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("t5_ack_once", ack_cnt, 1);

    // ACT stalled three cycles by cmd_ready
    do_ref();
    rdy_man = 1'b0;
    rdy_mode = 2;
    push_req(1'b1, 16'h0099, 10'h003, 6'd7, 16'h0000);
    @(posedge clk); #1;
    drive_req(1'b1, 16'h0099, 10'h003, 6'd7, 16'h0000);
    seen = 0;
    c = -1;
    for (int i = 0; i < BOUND && !seen; i++) begin
      @(negedge clk);
      if (bus.cmd_valid) begin seen = 1; c = cyc; end
    end
    check("t4_act_presented", seen, 1);
    check("t4_act_ra", {bus.cmd_op, bus.cmd_ra}, {2'd0, 16'h0099});
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("t4_stall_valid", bus.cmd_valid, 1);
      check("t4_stall_ra", bus.cmd_ra, 16'h0099);
      check("t4_stall_req_ready", bus.req_ready, 0);
    end
    rdy_man = 1'b1;
    wait_rr();
    check("t4_act_on_4th", t_act, c + 3);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rdy_mode = 0;

    // reset during the tRCD wait
    do_ref();
    push_req(1'b1, 16'h00AB, 10'h044, 6'd8, 16'h0000);
    @(posedge clk); #1;
    drive_req(1'b1, 16'h00AB, 10'h044, 6'd8, 16'h0000);
    seen = 0;
    for (int i = 0; i < BOUND && !seen; i++) begin
      @(negedge clk);
      if (bus.cmd_valid && bus.cmd_ready && bus.cmd_op == 2'd0) seen = 1;
    end
    check("t6_act_seen", seen, 1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check_outputs_zero("t6_async_reset");
    exp_q.delete();
    m_open = 1'b0;
    exp_rr--;
    t_act = -1000; t_pre = -1000; t_wr = -1000; t_rd = -1000;
    bus.req_valid = 1'b0;
    acc_before = acc_cnt;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("t6_no_cmd_after", acc_cnt, acc_before);
    check("t6_row_closed", bus.row_open, 0);

    // randomized traffic with random arbiter back-pressure
    rdy_mode = 1;
    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      if ($urandom_range(0, 5) == 0) do_ref();
      else do_req(1'($urandom_range(0, 1)), RA'($urandom_range(16'h10, 16'h13)),
                  CA'($urandom_range(0, 1023)), IDX'($urandom_range(0, 63)),
                  DQ'($urandom_range(0, 65535)));
    end
    repeat (4) @(posedge clk);
    #1;
    check("final_queue_empty", exp_q.size(), 0);
    check("final_req_ready_count", rr_cnt, exp_rr);
    check("final_ref_ack_count", ack_cnt, exp_ack);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
